// File: rtl/scrambler_pkg.sv
// Shared LFSR and framing definitions for the PRBS15 scrambler and descrambler.
// Both ends import this package, so the polynomial, taps and seed stay in step.
package scrambler_pkg;

    localparam int LFSR_W = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h4A80;

    // Taps of x^15 + x^14 + 1, as bit indices into the state register.
    localparam int TAP_HI = 14;
    localparam int TAP_LO = 13;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } state_t;

    // Keystream bit produced by the current LFSR state.
    function automatic logic lfsr_key(input logic [LFSR_W-1:0] s);
        return s[TAP_HI] ^ s[TAP_LO];
    endfunction

    // One Fibonacci step: shift left, feedback enters the LSB.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], lfsr_key(s)};
    endfunction

endpackage

// File: rtl/lfsr_frame_descrambler_if.sv
// Serial input and descrambled output bundle of the frame descrambler.
// The optional sync error counter exists only with DESCR_ERR_CNT_EN defined.
interface lfsr_frame_descrambler_if;

    logic                             serial_input;
    logic                             in_valid;
    logic                             data_out;
    logic                             data_valid;
    logic                             frame_start;
    logic                             locked;
    logic [scrambler_pkg::LFSR_W-1:0] lfsr_out;
`ifdef DESCR_ERR_CNT_EN
    logic [15:0]                      sync_err_cnt;

    modport master (
        output serial_input, in_valid,
        input  data_out, data_valid, frame_start, locked, lfsr_out, sync_err_cnt
    );
    modport slave (
        input  serial_input, in_valid,
        output data_out, data_valid, frame_start, locked, lfsr_out, sync_err_cnt
    );
`else
    modport master (
        output serial_input, in_valid,
        input  data_out, data_valid, frame_start, locked, lfsr_out
    );
    modport slave (
        input  serial_input, in_valid,
        output data_out, data_valid, frame_start, locked, lfsr_out
    );
`endif

endinterface

// File: rtl/lfsr_prbs15.sv
// PRBS15 generator (x^15 + x^14 + 1) with synchronous seed load and step enable.
// Load has priority over enable; key is the keystream bit for the current state.
module lfsr_prbs15
    import scrambler_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic              enable,
    output logic [LFSR_W-1:0] state,
    output logic              key
);

    logic [LFSR_W-1:0] state_reg;

    // Seed on reset or load, otherwise advance one step per enable.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= SEED;
        end else if (load) begin
            state_reg <= SEED;
        end else if (enable) begin
            state_reg <= lfsr_step(state_reg);
        end
    end

    assign state = state_reg;
    assign key   = lfsr_key(state_reg);

endmodule

// File: rtl/lfsr_frame_descrambler.sv
// Frame sync hunter and PRBS15 descrambler for the lfsr_scrambler serial stream.
// HUNT searches bit by bit for the sync word, VERIFY needs LOCK_COUNT good slots,
// LOCK flywheels over up to UNLOCK_COUNT-1 consecutive bad slots.
// Optional macro DESCR_ERR_CNT_EN adds a saturating count of bad slots in LOCK.
module lfsr_frame_descrambler
    import scrambler_pkg::*;
#(
    parameter int                  SYNC_LEN     = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD    = 8'h47,
    parameter int                  FRAME_LEN    = 64,
    parameter logic [LFSR_W-1:0]   SEED         = LFSR_SEED,
    parameter int                  LOCK_COUNT   = 3,
    parameter int                  UNLOCK_COUNT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    lfsr_frame_descrambler_if.slave  bus
);

    localparam int SLOT_LEN = FRAME_LEN + SYNC_LEN;
    localparam int POS_W    = $clog2(SLOT_LEN);
    localparam int GOOD_W   = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W   = $clog2(UNLOCK_COUNT + 1);

    localparam logic [POS_W-1:0] POS_LAST    = POS_W'(SLOT_LEN - 1);
    localparam logic [POS_W-1:0] POS_SYNC0   = POS_W'(FRAME_LEN);

    localparam logic [1:0] ST_HUNT   = HUNT;
    localparam logic [1:0] ST_VERIFY = VERIFY;
    localparam logic [1:0] ST_LOCK   = LOCK;

    logic [1:0]          state_reg,      state_next;
    logic [POS_W-1:0]    pos_reg,        pos_next;
    logic [GOOD_W-1:0]   good_cnt_reg,   good_cnt_next;
    logic [MISS_W-1:0]   miss_cnt_reg,   miss_cnt_next;
    logic [SYNC_LEN-1:0] sync_reg,       sync_next;
    logic                data_out_reg,   data_out_next;
    logic                data_valid_reg, data_valid_next;
    logic                frame_start_reg, frame_start_next;
`ifdef DESCR_ERR_CNT_EN
    logic [15:0]         err_cnt_reg,    err_cnt_next;
`endif

    logic [SYNC_LEN-1:0] sync_shift;
    logic [SYNC_LEN-1:0] bit_eq;
    logic                sync_match;
    logic                lfsr_load;
    logic                lfsr_en;
    logic [LFSR_W-1:0]   lfsr_state;
    logic                lfsr_key_bit;

    // The match is judged on the register value after this bit is shifted in.
    assign sync_shift = {sync_reg[SYNC_LEN-2:0], bus.serial_input};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_LEN; gi++) begin : g_match
            assign bit_eq[gi] = (sync_shift[gi] == SYNC_WORD[gi]);
        end
    endgenerate

    assign sync_match = &bit_eq;

    lfsr_prbs15 #(
        .SEED   (SEED)
    ) u_prbs (
        .clk    (clk),
        .srst   (reset),
        .load   (lfsr_load),
        .enable (lfsr_en),
        .state  (lfsr_state),
        .key    (lfsr_key_bit)
    );

    // Framing FSM, position tracking and payload descrambling for one input bit.
    always_comb begin
        state_next       = state_reg;
        pos_next         = pos_reg;
        good_cnt_next    = good_cnt_reg;
        miss_cnt_next    = miss_cnt_reg;
        sync_next        = sync_reg;
        data_out_next    = data_out_reg;
        data_valid_next  = 1'b0;
        frame_start_next = 1'b0;
        lfsr_load        = 1'b0;
        lfsr_en          = 1'b0;
`ifdef DESCR_ERR_CNT_EN
        err_cnt_next     = err_cnt_reg;
`endif
        if (bus.in_valid) begin
            sync_next = sync_shift;
            if (state_reg == ST_HUNT) begin
                // Any match is a candidate frame boundary, even inside payload.
                if (sync_match) begin
                    state_next    = ST_VERIFY;
                    pos_next      = '0;
                    good_cnt_next = GOOD_W'(1);
                    lfsr_load     = 1'b1;
                end
            end else if (state_reg == ST_VERIFY || state_reg == ST_LOCK) begin
                if (pos_reg < POS_SYNC0) begin
                    lfsr_en  = 1'b1;
                    pos_next = pos_reg + 1'b1;
                    if (state_reg == ST_LOCK) begin
                        data_out_next    = bus.serial_input ^ lfsr_key_bit;
                        data_valid_next  = 1'b1;
                        frame_start_next = (pos_reg == '0);
                    end
                end else if (pos_reg != POS_LAST) begin
                    pos_next = pos_reg + 1'b1;
                end else begin
                    // Sync slot complete: the next payload always starts from SEED.
                    pos_next  = '0;
                    lfsr_load = 1'b1;
                    if (state_reg == ST_VERIFY) begin
                        if (sync_match) begin
                            good_cnt_next = good_cnt_reg + 1'b1;
                            if (int'(good_cnt_reg) + 1 >= LOCK_COUNT) begin
                                state_next    = ST_LOCK;
                                miss_cnt_next = '0;
                            end
                        end else begin
                            state_next    = ST_HUNT;
                            good_cnt_next = '0;
                        end
                    end else begin
                        if (sync_match) begin
                            miss_cnt_next = '0;
                        end else begin
`ifdef DESCR_ERR_CNT_EN
                            if (err_cnt_reg != 16'hFFFF) begin
                                err_cnt_next = err_cnt_reg + 1'b1;
                            end
`endif
                            if (int'(miss_cnt_reg) + 1 >= UNLOCK_COUNT) begin
                                state_next    = ST_HUNT;
                                miss_cnt_next = '0;
                                good_cnt_next = '0;
                            end else begin
                                miss_cnt_next = miss_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
            end else begin
                // Unused encoding: fall back to hunting.
                state_next = ST_HUNT;
            end
        end
    end

    // State and output registers; reset overrides any in-flight frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_HUNT;
            pos_reg         <= '0;
            good_cnt_reg    <= '0;
            miss_cnt_reg    <= '0;
            sync_reg        <= '0;
            data_out_reg    <= 1'b0;
            data_valid_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
`ifdef DESCR_ERR_CNT_EN
            err_cnt_reg     <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            pos_reg         <= pos_next;
            good_cnt_reg    <= good_cnt_next;
            miss_cnt_reg    <= miss_cnt_next;
            sync_reg        <= sync_next;
            data_out_reg    <= data_out_next;
            data_valid_reg  <= data_valid_next;
            frame_start_reg <= frame_start_next;
`ifdef DESCR_ERR_CNT_EN
            err_cnt_reg     <= err_cnt_next;
`endif
        end
    end

    assign bus.data_out    = data_out_reg;
    assign bus.data_valid  = data_valid_reg;
    assign bus.frame_start = frame_start_reg;
    assign bus.locked      = (state_reg == ST_LOCK);
    assign bus.lfsr_out    = lfsr_state;
`ifdef DESCR_ERR_CNT_EN
    assign bus.sync_err_cnt = err_cnt_reg;
`else
    // Without the error counter the mismatch path only drives the FSM.
`endif

endmodule

// File: tb/tb_lfsr_frame_descrambler.sv
// Directed bench for lfsr_frame_descrambler: lock acquisition, PRBS check,
// flywheel, false sync, gapped input, mid-frame reset, optional error counter.
module tb_lfsr_frame_descrambler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    lfsr_frame_descrambler_if bus ();

    lfsr_frame_descrambler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] SEED_C = 15'h4A80;

    int          dv_cnt, fs_cnt, ones_cnt, mism_cnt, any_dv;
    logic        lock_at_sync, fs0;
    logic [4:0]  first5;
    logic [14:0] lfsr_b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One in_valid bit; outputs are sampled 1 time unit after the edge.
    task automatic send_bit(input logic b, input logic rst);
        @(negedge clk);
        bus.serial_input = b;
        bus.in_valid     = 1'b1;
        reset            = rst;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        reset        = 1'b0;
        if (bus.data_valid) any_dv++;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        if (bus.data_valid) any_dv++;
        if (bus.data_valid) dv_cnt++;
        if (bus.frame_start) fs_cnt++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_out"},    32'(bus.data_out),    32'd0);
        check({tag, "_data_valid"},  32'(bus.data_valid),  32'd0);
        check({tag, "_frame_start"}, 32'(bus.frame_start), 32'd0);
        check({tag, "_locked"},      32'(bus.locked),      32'd0);
        check({tag, "_lfsr_out"},    32'(bus.lfsr_out),    32'(SEED_C));
    endtask

    // Sync word (unscrambled) then 64 payload bits of value pbit, optionally
    // scrambled with a per-frame reseeded PRBS15, optionally gapped, optionally
    // cut by a reset at payload index abort_at.
    task automatic send_frame(input logic [7:0] sw, input logic pbit, input logic scr,
                              input logic gap, input int abort_at);
        logic [14:0] m;
        logic        key, t, exp_d;
        m = SEED_C;
        for (int i = 0; i < 8; i++) send_bit(sw[7-i], 1'b0);
        lock_at_sync = bus.locked;
        dv_cnt = 0; fs_cnt = 0; ones_cnt = 0; mism_cnt = 0;
        first5 = '0; lfsr_b1 = '0; fs0 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            key   = m[14] ^ m[13];
            t     = pbit ^ (scr & key);
            exp_d = t ^ key;
            if (i == abort_at) begin
                send_bit(t, 1'b1);
                check_reset_outputs("midframe_reset");
                return;
            end
            send_bit(t, 1'b0);
            m = {m[13:0], key};
            if (bus.data_valid) begin
                dv_cnt++;
                if (bus.data_out !== exp_d) mism_cnt++;
                if (bus.data_out) ones_cnt++;
            end
            if (bus.frame_start) fs_cnt++;
            if (i == 0) begin
                fs0     = bus.frame_start;
                lfsr_b1 = bus.lfsr_out;
            end
            if (i < 5) first5 = {first5[3:0], bus.data_out};
            if (gap) idle_cycle();
        end
    endtask

    initial begin
        bus.serial_input = 1'b0;
        bus.in_valid     = 1'b0;
        any_dv           = 0;

        // Reset held for two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
`ifdef DESCR_ERR_CNT_EN
        check("reset_err_cnt", 32'(bus.sync_err_cnt), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // Lock acquisition with scrambled all-ones payload.
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("acq_f1_locked", 32'(lock_at_sync), 32'd0);
        check("acq_f1_dv",     32'(dv_cnt),       32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("acq_f2_locked", 32'(lock_at_sync), 32'd0);
        check("acq_f2_dv",     32'(dv_cnt),       32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("acq_f3_locked", 32'(lock_at_sync), 32'd1);
        check("acq_f3_dv",     32'(dv_cnt),       32'd64);
        check("acq_f3_ones",   32'(ones_cnt),     32'd64);
        check("acq_f3_fs",     32'(fs_cnt),       32'd1);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("acq_f4_ones",   32'(ones_cnt),     32'd64);
        check("acq_f4_fs0",    32'(fs0),          32'd1);
        check("acq_f4_fs",     32'(fs_cnt),       32'd1);

        // Raw zero payload: data_out is the keystream itself.
        // Keystream from 4A80: 1,0,1,1,1; state after one step 0x1501.
        send_frame(8'h47, 1'b0, 1'b0, 1'b0, -1);
        check("prbs_lfsr_after_1", 32'(lfsr_b1),  32'h1501);
        check("prbs_first5",       32'(first5),   32'b10111);
        check("prbs_mism",         32'(mism_cnt), 32'd0);
        check("prbs_dv",           32'(dv_cnt),   32'd64);

        // Flywheel over single bad syncs, drop on two in a row.
        send_frame(8'h46, 1'b1, 1'b1, 1'b0, -1);
        check("fly_bad1_locked", 32'(lock_at_sync), 32'd1);
        check("fly_bad1_ones",   32'(ones_cnt),     32'd64);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("fly_good_locked", 32'(lock_at_sync), 32'd1);
        send_frame(8'h46, 1'b1, 1'b1, 1'b0, -1);
        check("fly_bad2_locked", 32'(lock_at_sync), 32'd1);
        check("fly_bad2_dv",     32'(dv_cnt),       32'd64);
        send_frame(8'h46, 1'b1, 1'b1, 1'b0, -1);
        check("fly_bad3_locked", 32'(lock_at_sync), 32'd0);
        check("fly_bad3_dv",     32'(dv_cnt),       32'd0);

        // False sync: 0x47 in zero filler, then a bad slot 72 bits later.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        any_dv = 0;
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h47 >> (7 - i)) & 8'h01) != 8'h00, 1'b0);
        for (int i = 0; i < 72; i++) send_bit(1'b0, 1'b0);
        check("false_sync_dv",     32'(any_dv),     32'd0);
        check("false_sync_locked", 32'(bus.locked), 32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("reacq1_locked", 32'(lock_at_sync), 32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("reacq2_locked", 32'(lock_at_sync), 32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("reacq3_locked", 32'(lock_at_sync), 32'd1);

        // Gapped payload must give the same bits as the continuous run.
        send_frame(8'h47, 1'b0, 1'b0, 1'b1, -1);
        check("gap_prbs_first5", 32'(first5),   32'b10111);
        check("gap_prbs_mism",   32'(mism_cnt), 32'd0);
        check("gap_prbs_dv",     32'(dv_cnt),   32'd64);
        check("gap_prbs_fs",     32'(fs_cnt),   32'd1);
        send_frame(8'h47, 1'b1, 1'b1, 1'b1, -1);
        check("gap_ones",        32'(ones_cnt), 32'd64);

        // Reset at payload bit 30, then reacquire over three frames.
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, 30);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("rst_reacq1_locked", 32'(lock_at_sync), 32'd0);
        check("rst_reacq1_dv",     32'(dv_cnt),       32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("rst_reacq2_locked", 32'(lock_at_sync), 32'd0);
        send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        check("rst_reacq3_locked", 32'(lock_at_sync), 32'd1);
        check("rst_reacq3_ones",   32'(ones_cnt),     32'd64);

`ifdef DESCR_ERR_CNT_EN
        // Five isolated bad syncs while locked.
        for (int k = 0; k < 5; k++) begin
            send_frame(8'h46, 1'b1, 1'b1, 1'b0, -1);
            send_frame(8'h47, 1'b1, 1'b1, 1'b0, -1);
        end
        check("err_cnt_locked", 32'(bus.locked),       32'd1);
        check("err_cnt_value",  32'(bus.sync_err_cnt), 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
